// File: rtl/cache_fill_ctrl_pkg.sv
// Shared types and constants for the cache miss/refill sequencer.
// Perf counters are built only with CACHE_FILL_PERF_CNT_EN defined.
package cache_fill_ctrl_pkg;

    localparam int unsigned DEF_NUM_THREADS  = 4;
    localparam int unsigned DEF_NUM_SET      = 16;
    localparam int unsigned DEF_WAYS_PER_SET = 4;
    localparam int unsigned DEF_ADDR_W       = 32;
    localparam int unsigned CACHE_PERF_CNT_W = 32;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        VICTIM   = 3'd1,
        MEM_REQ  = 3'd2,
        MEM_WAIT = 3'd3,
        FILL     = 3'd4
    } cache_fill_state_t;

    typedef enum logic {
        Multi_Threaded  = 1'b0,
        Single_Threaded = 1'b1
    } mt_t;

    // Saturating increment for the perf counters.
    function automatic logic [CACHE_PERF_CNT_W-1:0] sat_inc(input logic [CACHE_PERF_CNT_W-1:0] x);
        return (&x) ? x : x + CACHE_PERF_CNT_W'(1);
    endfunction

endpackage

// File: rtl/cache_fill_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping.
module rr_arbiter #(
    parameter int unsigned N     = 4,
    localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] idx
);

    always_comb begin : arb
        int unsigned j;
        logic        found;
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            j = (32'(ptr) + i) % N;
            if (!found && req[IDX_W'(j)]) begin
                found              = 1'b1;
                grant[IDX_W'(j)]   = 1'b1;
                idx                = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/cache_fill_ctrl.sv
// Per-cache miss/refill sequencer in front of the LRU; optional perf counters
// are enabled by defining CACHE_FILL_PERF_CNT_EN.
module cache_fill_ctrl
    import cache_fill_ctrl_pkg::*;
#(
    parameter int unsigned NUM_THREADS  = DEF_NUM_THREADS,
    parameter int unsigned NUM_SET      = DEF_NUM_SET,
    parameter int unsigned WAYS_PER_SET = DEF_WAYS_PER_SET,
    parameter int unsigned ADDR_W       = DEF_ADDR_W,
    localparam int unsigned THR_W       = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1,
    localparam int unsigned NUM_SET_W   = (NUM_SET > 1) ? $clog2(NUM_SET) : 1,
    localparam int unsigned WAYS_W      = (WAYS_PER_SET > 1) ? $clog2(WAYS_PER_SET) : 1
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  mt_t                                   mt_mode,
    input  logic [NUM_THREADS-1:0]                miss_req,
    input  logic [NUM_THREADS-1:0][NUM_SET_W-1:0] miss_set,
    input  logic [NUM_THREADS-1:0][ADDR_W-1:0]    miss_addr,
    output logic [NUM_THREADS-1:0]                miss_ack,
    input  logic                                  hit_valid,
    output logic                                  hit_ready,
    input  logic [NUM_SET_W-1:0]                  hit_set,
    input  logic [WAYS_W-1:0]                     hit_way,
    input  logic [THR_W-1:0]                      hit_thread,
    output logic                                  lru_victim_req,
    output logic [NUM_SET_W-1:0]                  lru_victim_set,
    input  logic [WAYS_W-1:0]                     lru_victim_way,
    output logic [THR_W-1:0]                      lru_thread_id,
    output logic                                  lru_update_req,
    output logic [NUM_SET_W-1:0]                  lru_update_set,
    output logic [WAYS_W-1:0]                     lru_update_way,
    output logic                                  mem_req_valid,
    input  logic                                  mem_req_ready,
    output logic [ADDR_W-1:0]                     mem_req_addr,
    input  logic                                  mem_rsp_valid,
    output logic                                  fill_valid,
    output logic [NUM_SET_W-1:0]                  fill_set,
    output logic [WAYS_W-1:0]                     fill_way,
    output logic                                  busy
`ifdef CACHE_FILL_PERF_CNT_EN
    ,
    output logic [NUM_THREADS-1:0][CACHE_PERF_CNT_W-1:0] perf_miss_cnt,
    output logic [CACHE_PERF_CNT_W-1:0]                  perf_wait_cnt
`endif
);

    cache_fill_state_t     state_q, state_d;
    logic [THR_W-1:0]      thr_q, thr_d;
    logic [THR_W-1:0]      ptr_q, ptr_d;
    logic [NUM_SET_W-1:0]  set_q, set_d;
    logic [WAYS_W-1:0]     way_q, way_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;

    logic [NUM_THREADS-1:0] req_elig_c;
    logic [NUM_THREADS-1:0] gnt_oh;
    logic [THR_W-1:0]       gnt_idx;
    logic                   single_c;

    assign single_c = (mt_mode == Single_Threaded);

    // Single-threaded mode only lets thread 0 compete.
    always_comb begin
        req_elig_c = miss_req;
        if (single_c) begin
            req_elig_c = '0;
            req_elig_c[0] = miss_req[0];
        end
    end

    rr_arbiter #(.N(NUM_THREADS)) u_arb (
        .req   (req_elig_c),
        .ptr   (ptr_q),
        .grant (gnt_oh),
        .idx   (gnt_idx)
    );

    always_comb begin
        state_d = state_q;
        thr_d   = thr_q;
        ptr_d   = ptr_q;
        set_d   = set_q;
        way_d   = way_q;
        addr_d  = addr_q;
        unique case (state_q)
            IDLE: begin
                if (|gnt_oh) begin
                    thr_d   = gnt_idx;
                    set_d   = miss_set[gnt_idx];
                    addr_d  = miss_addr[gnt_idx];
                    ptr_d   = (gnt_idx == THR_W'(NUM_THREADS - 1)) ? '0 : gnt_idx + THR_W'(1);
                    state_d = VICTIM;
                end
            end
            VICTIM: begin
                way_d   = lru_victim_way;
                state_d = MEM_REQ;
            end
            MEM_REQ:  if (mem_req_ready) state_d = MEM_WAIT;
            MEM_WAIT: if (mem_rsp_valid) state_d = FILL;
            FILL:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            thr_q   <= '0;
            ptr_q   <= '0;
            set_q   <= '0;
            way_q   <= '0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            thr_q   <= thr_d;
            ptr_q   <= ptr_d;
            set_q   <= set_d;
            way_q   <= way_d;
            addr_q  <= addr_d;
        end
    end

    // Hit-path outputs pass inputs straight through, so they are gated by reset to stay 0.
    always_comb begin
        miss_ack       = '0;
        hit_ready      = 1'b0;
        lru_victim_req = 1'b0;
        lru_victim_set = set_q;
        lru_thread_id  = '0;
        lru_update_req = 1'b0;
        lru_update_set = '0;
        lru_update_way = '0;
        mem_req_valid  = 1'b0;
        mem_req_addr   = addr_q;
        fill_valid     = 1'b0;
        fill_set       = set_q;
        fill_way       = way_q;
        busy           = (state_q != IDLE);
        if (reset) begin
            hit_ready      = 1'b1;
            lru_thread_id  = single_c ? '0 : hit_thread;
            lru_update_req = hit_valid;
            lru_update_set = hit_set;
            lru_update_way = hit_way;
        end
        unique case (state_q)
            VICTIM: begin
                lru_victim_req = 1'b1;
                lru_thread_id  = thr_q;
            end
            MEM_REQ: mem_req_valid = 1'b1;
            FILL: begin
                hit_ready        = 1'b0;
                lru_thread_id    = thr_q;
                lru_update_req   = 1'b1;
                lru_update_set   = set_q;
                lru_update_way   = way_q;
                fill_valid       = 1'b1;
                miss_ack[thr_q]  = 1'b1;
            end
            default: ;
        endcase
    end

    rsp_only_in_wait_a: assert property (@(posedge clock) disable iff (!reset)
        mem_rsp_valid |-> state_q == MEM_WAIT);

`ifdef CACHE_FILL_PERF_CNT_EN
    logic [NUM_THREADS-1:0][CACHE_PERF_CNT_W-1:0] miss_cnt_q, miss_cnt_d;
    logic [CACHE_PERF_CNT_W-1:0]                  wait_cnt_q, wait_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        wait_cnt_d = wait_cnt_q;
        if (state_q == FILL) miss_cnt_d[thr_q] = sat_inc(miss_cnt_q[thr_q]);
        if (state_q == MEM_WAIT) wait_cnt_d = sat_inc(wait_cnt_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            miss_cnt_q <= '0;
            wait_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign perf_miss_cnt = miss_cnt_q;
    assign perf_wait_cnt = wait_cnt_q;
`endif

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Directed bench for cache_fill_ctrl: single miss, RR order, backpressure,
// hit collision, single-threaded masking and mid-fill reset.
module tb_cache_fill_ctrl;
    import cache_fill_ctrl_pkg::*;

    localparam int unsigned NT  = 4;
    localparam int unsigned NS  = 16;
    localparam int unsigned NW  = 4;
    localparam int unsigned AW  = 32;
    localparam int unsigned TW  = 2;
    localparam int unsigned SW  = 4;
    localparam int unsigned WW  = 2;

    logic                      clock = 1'b0;
    logic                      reset;
    mt_t                       mt_mode;
    logic [NT-1:0]             miss_req;
    logic [NT-1:0][SW-1:0]     miss_set;
    logic [NT-1:0][AW-1:0]     miss_addr;
    logic [NT-1:0]             miss_ack;
    logic                      hit_valid;
    logic                      hit_ready;
    logic [SW-1:0]             hit_set;
    logic [WW-1:0]             hit_way;
    logic [TW-1:0]             hit_thread;
    logic                      lru_victim_req;
    logic [SW-1:0]             lru_victim_set;
    logic [WW-1:0]             lru_victim_way;
    logic [TW-1:0]             lru_thread_id;
    logic                      lru_update_req;
    logic [SW-1:0]             lru_update_set;
    logic [WW-1:0]             lru_update_way;
    logic                      mem_req_valid;
    logic                      mem_req_ready;
    logic [AW-1:0]             mem_req_addr;
    logic                      mem_rsp_valid;
    logic                      fill_valid;
    logic [SW-1:0]             fill_set;
    logic [WW-1:0]             fill_way;
    logic                      busy;
`ifdef CACHE_FILL_PERF_CNT_EN
    logic [NT-1:0][31:0]       perf_miss_cnt;
    logic [31:0]               perf_wait_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clock = ~clock;

    cache_fill_ctrl #(
        .NUM_THREADS(NT), .NUM_SET(NS), .WAYS_PER_SET(NW), .ADDR_W(AW)
    ) dut (
        .clock(clock), .reset(reset), .mt_mode(mt_mode),
        .miss_req(miss_req), .miss_set(miss_set), .miss_addr(miss_addr), .miss_ack(miss_ack),
        .hit_valid(hit_valid), .hit_ready(hit_ready), .hit_set(hit_set), .hit_way(hit_way),
        .hit_thread(hit_thread),
        .lru_victim_req(lru_victim_req), .lru_victim_set(lru_victim_set),
        .lru_victim_way(lru_victim_way), .lru_thread_id(lru_thread_id),
        .lru_update_req(lru_update_req), .lru_update_set(lru_update_set),
        .lru_update_way(lru_update_way),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_rsp_valid(mem_rsp_valid),
        .fill_valid(fill_valid), .fill_set(fill_set), .fill_way(fill_way), .busy(busy)
`ifdef CACHE_FILL_PERF_CNT_EN
        , .perf_miss_cnt(perf_miss_cnt), .perf_wait_cnt(perf_wait_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one cycle and settle just after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Service one miss for thread t with a memory that stalls ready_wait cycles.
    task automatic serve(input int t, input logic [WW-1:0] way, input int ready_wait,
                         input bit hit_fill, output int waited);
        logic [31:0] exp_ack;
        exp_ack = 32'(1) << t;
        lru_victim_way = way;
        waited = 0;
        for (int k = 0; k < 12; k++) begin
            if (lru_victim_req) break;
            tick();
            waited++;
        end
        check_eq("victim_req", 32'(lru_victim_req), 32'd1);
        check_eq("victim_thread", 32'(lru_thread_id), 32'(t));
        check_eq("victim_set", 32'(lru_victim_set), 32'(miss_set[t]));
        tick();
        mem_req_ready = 1'b0;
        for (int k = 0; k < ready_wait; k++) begin
            check_eq("req_valid_held", 32'(mem_req_valid), 32'd1);
            check_eq("req_addr_stable", mem_req_addr, miss_addr[t]);
            check_eq("no_early_ack", 32'(miss_ack), 32'd0);
            tick();
        end
        mem_req_ready = 1'b1;
        check_eq("req_valid", 32'(mem_req_valid), 32'd1);
        check_eq("req_addr", mem_req_addr, miss_addr[t]);
        tick();
        check_eq("one_handshake", 32'(mem_req_valid), 32'd0);
        check_eq("wait_no_ack", 32'(miss_ack), 32'd0);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        if (hit_fill) begin
            hit_valid = 1'b1; hit_set = 4'd7; hit_way = 2'd1; hit_thread = 2'd3;
            #1;
            check_eq("hit_stall", 32'(hit_ready), 32'd0);
        end
        check_eq("fill_valid", 32'(fill_valid), 32'd1);
        check_eq("fill_set", 32'(fill_set), 32'(miss_set[t]));
        check_eq("fill_way", 32'(fill_way), 32'(way));
        check_eq("fill_upd_req", 32'(lru_update_req), 32'd1);
        check_eq("fill_upd_set", 32'(lru_update_set), 32'(miss_set[t]));
        check_eq("fill_upd_way", 32'(lru_update_way), 32'(way));
        check_eq("miss_ack", 32'(miss_ack), exp_ack);
        miss_req[t] = 1'b0;
        tick();
        check_eq("ack_pulse", 32'(miss_ack), 32'd0);
        if (hit_fill) begin
            check_eq("hit_ready_after", 32'(hit_ready), 32'd1);
            check_eq("hit_upd_req", 32'(lru_update_req), 32'd1);
            check_eq("hit_upd_set", 32'(lru_update_set), 32'd7);
            check_eq("hit_upd_way", 32'(lru_update_way), 32'd1);
            check_eq("hit_upd_thr", 32'(lru_thread_id), 32'd3);
            hit_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        reset = 1'b0; mt_mode = Multi_Threaded; miss_req = '0;
        hit_valid = 1'b0; hit_set = '0; hit_way = '0; hit_thread = '0;
        lru_victim_way = '0; mem_req_ready = 1'b1; mem_rsp_valid = 1'b0;
        for (int t = 0; t < NT; t++) begin
            miss_set[t]  = SW'(t + 1);
            miss_addr[t] = 32'h2000 + 32'(t) * 32'h40;
        end
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ack", 32'(miss_ack), 32'd0);
        check_eq("rst_memv", 32'(mem_req_valid), 32'd0);
        check_eq("rst_hit_ready", 32'(hit_ready), 32'd0);
        tick();
        reset = 1'b1;
        tick();

        // 1: single miss, minimum latency
        miss_set[0] = 4'd5; miss_addr[0] = 32'h1000; miss_req[0] = 1'b1;
        #1;
        check_eq("t1_idle_busy", 32'(busy), 32'd0);
        serve(0, 2'd2, 0, 1'b0, w);
        check_eq("t1_victim_latency", 32'(w), 32'd1);

        // 2: round robin fairness
        do_reset();
        miss_set[0] = 4'd1; miss_addr[0] = 32'h2000;
        miss_req = 4'b1111;
        for (int t = 0; t < NT; t++) serve(t, WW'(t), 0, 1'b0, w);
        miss_req[0] = 1'b1; miss_req[2] = 1'b1;
        serve(0, 2'd3, 0, 1'b0, w);
        serve(2, 2'd1, 0, 1'b0, w);

        // 3: memory backpressure
        miss_req[1] = 1'b1;
        serve(1, 2'd3, 6, 1'b0, w);

        // 4: hit outside FILL passes through, hit during FILL stalls
        hit_valid = 1'b1; hit_set = 4'd3; hit_way = 2'd2; hit_thread = 2'd1;
        #1;
        check_eq("hit_idle_req", 32'(lru_update_req), 32'd1);
        check_eq("hit_idle_set", 32'(lru_update_set), 32'd3);
        check_eq("hit_idle_thr", 32'(lru_thread_id), 32'd1);
        check_eq("hit_idle_ready", 32'(hit_ready), 32'd1);
        hit_valid = 1'b0;
        miss_req[3] = 1'b1;
        serve(3, 2'd0, 0, 1'b1, w);

        // 5: single-threaded masking
        mt_mode = Single_Threaded;
        miss_req = 4'b0110;
        hit_valid = 1'b1; hit_thread = 2'd2;
        #1;
        check_eq("st_hit_thr", 32'(lru_thread_id), 32'd0);
        hit_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_eq("st_busy", 32'(busy), 32'd0);
        end
        miss_req[0] = 1'b1;
        serve(0, 2'd2, 0, 1'b0, w);
        tick();
        check_eq("st_still_idle", 32'(busy), 32'd0);
        miss_req = '0;
        mt_mode = Multi_Threaded;

        // 6: reset while waiting for memory
        miss_req[2] = 1'b1;
        tick();
        check_eq("t6_victim", 32'(lru_victim_req), 32'd1);
        tick();
        tick();
        check_eq("t6_wait_busy", 32'(busy), 32'd1);
        hit_valid = 1'b1; hit_set = 4'd7;
        reset = 1'b0;
        #1;
        check_eq("t6_rst_busy", 32'(busy), 32'd0);
        check_eq("t6_rst_upd", 32'(lru_update_req), 32'd0);
        check_eq("t6_rst_hit_ready", 32'(hit_ready), 32'd0);
        check_eq("t6_rst_addr", mem_req_addr, 32'd0);
        check_eq("t6_rst_fill", 32'(fill_valid), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            check_eq("t6_rst_ack", 32'(miss_ack), 32'd0);
        end
        reset = 1'b1;
        hit_valid = 1'b0;
        serve(2, 2'd1, 0, 1'b0, w);
        check_eq("t6_restart_latency", 32'(w), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
